// File: rtl/bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter_if
// Bundles the two core-side req/gnt/rvalid ports and the BRAM-side bus that
// bram_port_arbiter multiplexes.
//   requester n (n = 0,1): reqn_i, gntn_o, rvalidn_o, addrn_i, wen_i, ben_i,
//                          wdatan_i, rdatan_o
//   BRAM side: addr, dout (write data), din (read data), weout (byte enables)
// Modports:
//   slave  - the arbiter itself
//   master - whatever drives the requests and models the BRAM
// ---------------------------------------------------------------------------
interface bram_port_arbiter_if;
   logic        req0_i, gnt0_o, rvalid0_o, we0_i;
   logic [3:0]  be0_i;
   logic [31:0] addr0_i, wdata0_i, rdata0_o;
   logic        req1_i, gnt1_o, rvalid1_o, we1_i;
   logic [3:0]  be1_i;
   logic [31:0] addr1_i, wdata1_i, rdata1_o;
   logic [31:0] addr, dout, din;
   logic [3:0]  weout;

   modport slave (
      input  req0_i, addr0_i, we0_i, be0_i, wdata0_i,
      input  req1_i, addr1_i, we1_i, be1_i, wdata1_i,
      input  din,
      output gnt0_o, rvalid0_o, rdata0_o,
      output gnt1_o, rvalid1_o, rdata1_o,
      output addr, dout, weout
   );

   modport master (
      output req0_i, addr0_i, we0_i, be0_i, wdata0_i,
      output req1_i, addr1_i, we1_i, be1_i, wdata1_i,
      output din,
      input  gnt0_o, rvalid0_o, rdata0_o,
      input  gnt1_o, rvalid1_o, rdata1_o,
      input  addr, dout, weout
   );
endinterface

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
// Shares one single-port BRAM between two req/gnt/rvalid requesters.
// Round-robin arbitration picks at most one request per cycle and drives the
// BRAM bus; a response pipeline R_LATENCY_IN_CYCLES deep remembers who issued
// each accepted access so rvalid/rdata return to that requester exactly when
// the BRAM read data is available.
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   bus          requester ports and BRAM bus (slave modport)
//   stall_cnt_o  saturating count of cycles in which a request was refused
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int R_LATENCY_IN_CYCLES = 1,
   parameter int STALL_CNT_W         = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   bram_port_arbiter_if.slave     bus,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);
   localparam int L = R_LATENCY_IN_CYCLES;

   // last_q = 1 means requester 1 was granted most recently
   logic                   last_q, last_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   // response pipeline, stage 0 loaded on grant, stage L-1 drives responses
   logic [L-1:0]           valid_q, valid_d;
   logic [L-1:0]           id_q, id_d;
   logic [L-1:0]           wr_q, wr_d;

   logic gnt0, gnt1, win_we, refused;

   always_comb begin
      // Gating with rst_ni keeps grants and BRAM writes quiet while reset
      // is held, regardless of what the requesters present.
      gnt0   = rst_ni & bus.req0_i & (~bus.req1_i | last_q);
      gnt1   = rst_ni & bus.req1_i & ~gnt0;
      win_we = gnt1 ? bus.we1_i : (gnt0 & bus.we0_i);

      bus.gnt0_o = gnt0;
      bus.gnt1_o = gnt1;
      bus.addr   = '0;
      bus.dout   = '0;
      bus.weout  = '0;
      if (gnt0) begin
         bus.addr = bus.addr0_i;
         if (bus.we0_i) begin
            bus.dout  = bus.wdata0_i;
            bus.weout = bus.be0_i;
         end
      end else if (gnt1) begin
         bus.addr = bus.addr1_i;
         if (bus.we1_i) begin
            bus.dout  = bus.wdata1_i;
            bus.weout = bus.be1_i;
         end
      end

      last_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);

      // With two requesters at most one can be refused per cycle.
      refused     = (bus.req0_i & ~gnt0) | (bus.req1_i & ~gnt1);
      stall_cnt_d = stall_cnt_q;
      if (refused && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end

      valid_d[0] = gnt0 | gnt1;
      id_d[0]    = gnt1;
      wr_d[0]    = win_we;
      for (int i = 1; i < L; i++) begin
         valid_d[i] = valid_q[i-1];
         id_d[i]    = id_q[i-1];
         wr_d[i]    = wr_q[i-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q      <= 1'b1;
         stall_cnt_q <= '0;
         valid_q     <= '0;
         id_q        <= '0;
         wr_q        <= '0;
      end else begin
         last_q      <= last_d;
         stall_cnt_q <= stall_cnt_d;
         valid_q     <= valid_d;
         id_q        <= id_d;
         wr_q        <= wr_d;
      end
   end

   // Responses: writes still return rvalid, but with zero data.
   always_comb begin
      bus.rvalid0_o = rst_ni & valid_q[L-1] & ~id_q[L-1];
      bus.rvalid1_o = rst_ni & valid_q[L-1] &  id_q[L-1];
      bus.rdata0_o  = (bus.rvalid0_o && !wr_q[L-1]) ? bus.din : 32'd0;
      bus.rdata1_o  = (bus.rvalid1_o && !wr_q[L-1]) ? bus.din : 32'd0;
   end

   assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
// Two arbiter instances share one clock: instance 0 with latency 1 and a
// 16-bit stall counter, instance 1 with latency 3 and a 4-bit stall counter.
// Grant-cycle BRAM drive is checked against a vector table or a small
// round-robin model; every expected response goes into a scoreboard queue
// with its due cycle and is compared when that cycle is reached.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;
   typedef struct packed {
      logic        r0, w0;
      logic [3:0]  b0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [3:0]  b1;
      logic [31:0] a1, d1, din;
   } in_t;

   typedef struct {
      in_t         i;
      logic        g0, g1;
      logic [31:0] ad, dout;
      logic [3:0]  we;
   } vec_t;

   typedef struct {
      int inst;
      bit id;
      bit wr;
      int due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n [2];
   in_t         drv [2];
   logic        g0_w [2], g1_w [2], rv0_w [2], rv1_w [2];
   logic [31:0] rd0_w [2], rd1_w [2], addr_w [2], dout_w [2];
   logic [3:0]  we_w [2];
   logic [15:0] stall_w [2];

   exp_t sb [$];
   bit   ptr [2];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      localparam int W   = (gi == 0) ? 16 : 4;
      logic [W-1:0] st;
      bram_port_arbiter_if bus ();
      bram_port_arbiter #(.R_LATENCY_IN_CYCLES(LAT), .STALL_CNT_W(W)) u_dut (
         .clk_i(clk), .rst_ni(rst_n[gi]), .bus(bus), .stall_cnt_o(st));
      assign bus.req0_i   = drv[gi].r0;
      assign bus.we0_i    = drv[gi].w0;
      assign bus.be0_i    = drv[gi].b0;
      assign bus.addr0_i  = drv[gi].a0;
      assign bus.wdata0_i = drv[gi].d0;
      assign bus.req1_i   = drv[gi].r1;
      assign bus.we1_i    = drv[gi].w1;
      assign bus.be1_i    = drv[gi].b1;
      assign bus.addr1_i  = drv[gi].a1;
      assign bus.wdata1_i = drv[gi].d1;
      assign bus.din      = drv[gi].din;
      assign g0_w[gi]     = bus.gnt0_o;
      assign g1_w[gi]     = bus.gnt1_o;
      assign rv0_w[gi]    = bus.rvalid0_o;
      assign rv1_w[gi]    = bus.rvalid1_o;
      assign rd0_w[gi]    = bus.rdata0_o;
      assign rd1_w[gi]    = bus.rdata1_o;
      assign addr_w[gi]   = bus.addr;
      assign dout_w[gi]   = bus.dout;
      assign we_w[gi]     = bus.weout;
      assign stall_w[gi]  = 16'(st);
   end

   function automatic int lat(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic vec_t mkv(logic r0, w0, logic [3:0] b0, logic [31:0] a0, d0,
                                logic r1, w1, logic [3:0] b1, logic [31:0] a1, d1,
                                logic [31:0] din, logic g0, g1,
                                logic [31:0] ad, dout, logic [3:0] we);
      vec_t v;
      v.i  = '{r0: r0, w0: w0, b0: b0, a0: a0, d0: d0,
               r1: r1, w1: w1, b1: b1, a1: a1, d1: d1, din: din};
      v.g0 = g0;  v.g1 = g1;  v.ad = ad;  v.dout = dout;  v.we = we;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare responses of both instances against the scoreboard heads.
   task automatic monitor();
      for (int i = 0; i < 2; i++) begin
         logic        ev0, ev1;
         logic [31:0] ed0, ed1;
         int          k;
         ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0; k = -1;
         for (int j = 0; j < sb.size(); j++) begin
            if (sb[j].inst == i && k < 0) k = j;
         end
         if (k >= 0 && sb[k].due == cyc) begin
            if (sb[k].id) begin
               ev1 = 1'b1;
               ed1 = sb[k].wr ? 32'd0 : drv[i].din;
            end else begin
               ev0 = 1'b1;
               ed0 = sb[k].wr ? 32'd0 : drv[i].din;
            end
            $display("resp dut%0d id%0d wr=%0d cycle %0d rdata0=%08h rdata1=%08h",
                     i, sb[k].id, sb[k].wr, cyc, rd0_w[i], rd1_w[i]);
            sb.delete(k);
         end
         check($sformatf("rvalid0[%0d]", i), 32'(rv0_w[i]), 32'(ev0));
         check($sformatf("rvalid1[%0d]", i), 32'(rv1_w[i]), 32'(ev1));
         if (ev0 || ev1) begin
            check($sformatf("rdata0[%0d]", i), rd0_w[i], ed0);
            check($sformatf("rdata1[%0d]", i), rd1_w[i], ed1);
         end
      end
   endtask

   task automatic step(in_t va, in_t vb, logic ra, logic rb);
      @(posedge clk);
      #1;
      cyc++;
      rst_n[0] = ra;
      rst_n[1] = rb;
      drv[0]   = va;
      drv[1]   = vb;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n[i]) begin
            ptr[i] = 1'b1;
            for (int j = sb.size() - 1; j >= 0; j--) begin
               if (sb[j].inst == i) sb.delete(j);
            end
         end
      end
      @(negedge clk);
      monitor();
   endtask

   task automatic expect_bus(int i, logic g0, logic g1, logic [31:0] ad,
                             logic [31:0] dout, logic [3:0] we);
      bit wr;
      check($sformatf("gnt0[%0d]", i), 32'(g0_w[i]), 32'(g0));
      check($sformatf("gnt1[%0d]", i), 32'(g1_w[i]), 32'(g1));
      check($sformatf("addr[%0d]", i), addr_w[i], ad);
      check($sformatf("dout[%0d]", i), dout_w[i], dout);
      check($sformatf("weout[%0d]", i), 32'(we_w[i]), 32'(we));
      if (g0 || g1) begin
         ptr[i] = g1;
         wr = g1 ? drv[i].w1 : drv[i].w0;
         sb.push_back('{inst: i, id: g1, wr: wr, due: cyc + lat(i)});
         $display("gnt  dut%0d id%0d wr=%0d cycle %0d addr=%08h", i, g1, wr, cyc, ad);
      end
   endtask

   // Round-robin reference: on conflict the requester not granted last wins.
   task automatic expect_model(int i);
      in_t         v;
      int          win;
      logic [31:0] a, d;
      logic [3:0]  w;
      v = drv[i];
      if (v.r0 && v.r1) win = ptr[i] ? 0 : 1;
      else if (v.r0)    win = 0;
      else if (v.r1)    win = 1;
      else              win = -1;
      a = '0; d = '0; w = '0;
      if (win == 0) begin
         a = v.a0;
         if (v.w0) begin d = v.d0; w = v.b0; end
      end else if (win == 1) begin
         a = v.a1;
         if (v.w1) begin d = v.d1; w = v.b1; end
      end
      expect_bus(i, win == 0, win == 1, a, d, w);
   endtask

   task automatic check_reset_quiet(int i);
      check($sformatf("rst_gnt0[%0d]", i), 32'(g0_w[i]), 32'd0);
      check($sformatf("rst_gnt1[%0d]", i), 32'(g1_w[i]), 32'd0);
      check($sformatf("rst_weout[%0d]", i), 32'(we_w[i]), 32'd0);
      check($sformatf("rst_addr[%0d]", i), addr_w[i], 32'd0);
      check($sformatf("rst_dout[%0d]", i), dout_w[i], 32'd0);
      check($sformatf("rst_rdata0[%0d]", i), rd0_w[i], 32'd0);
      check($sformatf("rst_rdata1[%0d]", i), rd1_w[i], 32'd0);
      check($sformatf("rst_stall[%0d]", i), 32'(stall_w[i]), 32'd0);
   endtask

   initial begin
      vec_t vecs [11];
      in_t  idle, busy, v;

      vecs[0]  = mkv(0,0,4'h0,32'h0,32'h0,        0,0,4'h0,32'h0,32'h0,        32'h0,        0,0,32'h0,  32'h0,        4'h0);
      vecs[1]  = mkv(1,0,4'hF,32'h100,32'h0,      0,0,4'h0,32'h0,32'h0,        32'h0,        1,0,32'h100,32'h0,        4'h0);
      vecs[2]  = mkv(0,0,4'h0,32'h0,32'h0,        0,0,4'h0,32'h0,32'h0,        32'hDEADBEEF, 0,0,32'h0,  32'h0,        4'h0);
      vecs[3]  = mkv(0,0,4'h0,32'h0,32'h0,        1,1,4'h3,32'h40,32'h12345678,32'h0,        0,1,32'h40, 32'h12345678, 4'h3);
      vecs[4]  = mkv(0,0,4'h0,32'h0,32'h0,        0,0,4'h0,32'h0,32'h0,        32'hAAAA5555, 0,0,32'h0,  32'h0,        4'h0);
      vecs[5]  = mkv(1,1,4'hC,32'h8,32'hCAFEF00D, 1,0,4'hF,32'h10,32'h0,       32'h0,        1,0,32'h8,  32'hCAFEF00D, 4'hC);
      vecs[6]  = mkv(1,0,4'hF,32'h20,32'h0,       1,0,4'hF,32'h10,32'h0,       32'h11111111, 0,1,32'h10, 32'h0,        4'h0);
      vecs[7]  = mkv(1,0,4'hF,32'h20,32'h0,       0,0,4'h0,32'h0,32'h0,        32'h22222222, 1,0,32'h20, 32'h0,        4'h0);
      vecs[8]  = mkv(0,0,4'h0,32'h0,32'h0,        1,0,4'hF,32'h30,32'hFFFFFFFF,32'h33333333, 0,1,32'h30, 32'h0,        4'h0);
      vecs[9]  = mkv(0,0,4'h0,32'h0,32'h0,        0,0,4'h0,32'h0,32'h0,        32'h44444444, 0,0,32'h0,  32'h0,        4'h0);
      vecs[10] = mkv(0,0,4'h0,32'h0,32'h0,        0,0,4'h0,32'h0,32'h0,        32'h0,        0,0,32'h0,  32'h0,        4'h0);

      idle     = '0;
      rst_n[0] = 1'b0;
      rst_n[1] = 1'b0;
      drv[0]   = idle;
      drv[1]   = idle;
      ptr[0]   = 1'b1;
      ptr[1]   = 1'b1;

      // Reset held with writes requested on both ports: everything stays quiet.
      busy = '{r0: 1'b1, w0: 1'b1, b0: 4'hF, a0: 32'h10, d0: 32'h55,
               r1: 1'b1, w1: 1'b1, b1: 4'hF, a1: 32'h20, d1: 32'h66, din: 32'h77};
      step(busy, busy, 1'b0, 1'b0);
      step(busy, busy, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) check_reset_quiet(i);
      step(idle, idle, 1'b1, 1'b1);

      // Vector table on the latency-1 instance.
      for (int k = 0; k < 11; k++) begin
         step(vecs[k].i, idle, 1'b1, 1'b1);
         expect_bus(0, vecs[k].g0, vecs[k].g1, vecs[k].ad, vecs[k].dout, vecs[k].we);
      end
      check("stall_after_table", 32'(stall_w[0]), 32'd2);

      // Latency 1: both requesting from reset alternate 0,1,0,1.
      step(idle, idle, 1'b0, 1'b1);
      v = '{r0: 1'b1, w0: 1'b0, b0: 4'hF, a0: 32'h200, d0: 32'h0,
            r1: 1'b1, w1: 1'b0, b1: 4'hF, a1: 32'h300, d1: 32'h0, din: 32'h0};
      for (int k = 0; k < 4; k++) begin
         v.din = 32'hA0000000 | 32'(k);
         step(v, idle, 1'b1, 1'b1);
         check("alt_stall", 32'(stall_w[0]), 32'(k));
         check("alt_gnt0", 32'(g0_w[0]), 32'(k % 2 == 0));
         expect_model(0);
      end
      step(idle, idle, 1'b1, 1'b1);
      check("alt_stall_final", 32'(stall_w[0]), 32'd4);

      // Latency 3: back-to-back reads from requester 0.
      for (int k = 0; k < 3; k++) begin
         v = idle;
         v.r0 = 1'b1; v.b0 = 4'hF; v.a0 = 32'(k * 4); v.din = 32'hB0000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
         expect_model(1);
      end
      for (int k = 0; k < 4; k++) begin
         v = idle;
         v.din = 32'hC0000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
         expect_model(1);
      end

      // 4-bit stall counter saturates under 20 cycles of contention.
      v = '{r0: 1'b1, w0: 1'b0, b0: 4'hF, a0: 32'h500, d0: 32'h0,
            r1: 1'b1, w1: 1'b1, b1: 4'h5, a1: 32'h600, d1: 32'h5A5A5A5A, din: 32'h0};
      for (int k = 0; k < 20; k++) begin
         v.din = 32'hD0000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
         check("sat_stall", 32'(stall_w[1]), 32'((k < 15) ? k : 15));
         expect_model(1);
      end
      for (int k = 0; k < 4; k++) begin
         v = idle;
         v.din = 32'hE0000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
         if (k == 0) check("sat_stall_final", 32'(stall_w[1]), 32'd15);
         expect_model(1);
      end

      // Latency 3: reset pulse with two reads in flight drops both responses.
      for (int k = 0; k < 2; k++) begin
         v = idle;
         v.r0 = 1'b1; v.b0 = 4'hF; v.a0 = 32'h700 + 32'(k * 4); v.din = 32'hF0000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
         expect_model(1);
      end
      v = '{r0: 1'b1, w0: 1'b1, b0: 4'hF, a0: 32'h800, d0: 32'h99,
            r1: 1'b0, w1: 1'b0, b1: 4'h0, a1: 32'h0, d1: 32'h0, din: 32'hF00000AA};
      step(idle, v, 1'b1, 1'b0);
      check("pulse_gnt0", 32'(g0_w[1]), 32'd0);
      check("pulse_gnt1", 32'(g1_w[1]), 32'd0);
      check("pulse_weout", 32'(we_w[1]), 32'd0);
      check("pulse_stall", 32'(stall_w[1]), 32'd0);
      for (int k = 0; k < 5; k++) begin
         v = idle;
         v.din = 32'hF1000000 | 32'(k);
         step(idle, v, 1'b1, 1'b1);
      end
      check("pulse_stall_after", 32'(stall_w[1]), 32'd0);

      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
